// File: rtl/csr_file.sv
// Machine-mode CSR file: atomic read-modify-write port for the EXU, trap/mret
// event handling, 64-bit counters with inhibit, and a synchronised mip.
module csr_file #(
    parameter int          HPM_NUM   = 2,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [1:0]                             exu_op_i,
    input  logic [11:0]                            exu_addr_i,
    input  logic [31:0]                            exu_data_i,
    output logic [31:0]                            exu_data_o,
    output logic                                   exu_illegal_o,
    input  logic                                   retire_i,
    input  logic [(HPM_NUM > 0 ? HPM_NUM : 1)-1:0] hpm_event_i,
    input  logic                                   trap_i,
    input  logic [31:0]                            trap_pc_i,
    input  logic [31:0]                            trap_cause_i,
    input  logic                                   mret_i,
    input  logic                                   irq_ext_i,
    input  logic                                   irq_timer_i,
    input  logic                                   irq_soft_i,
    output logic [31:0]                            csr_mtvec_o,
    output logic [31:0]                            csr_mepc_o,
    output logic [31:0]                            csr_mstatus_o,
    output logic                                   irq_pending_o
);

    localparam int HPM_W = (HPM_NUM > 0) ? HPM_NUM : 1;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    localparam logic [11:0] A_MSTATUS       = 12'h300;
    localparam logic [11:0] A_MIE           = 12'h304;
    localparam logic [11:0] A_MTVEC         = 12'h305;
    localparam logic [11:0] A_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] A_MSCRATCH      = 12'h340;
    localparam logic [11:0] A_MEPC          = 12'h341;
    localparam logic [11:0] A_MCAUSE        = 12'h342;
    localparam logic [11:0] A_MIP           = 12'h344;
    localparam logic [11:0] A_MCYCLE        = 12'hB00;
    localparam logic [11:0] A_MINSTRET      = 12'hB02;
    localparam logic [11:0] A_MCYCLEH       = 12'hB80;
    localparam logic [11:0] A_MINSTRETH     = 12'hB82;
    localparam logic [11:0] A_CYCLE         = 12'hC00;
    localparam logic [11:0] A_INSTRET       = 12'hC02;
    localparam logic [11:0] A_CYCLEH        = 12'hC80;
    localparam logic [11:0] A_INSTRETH      = 12'hC82;

    localparam logic [31:0] MIE_MASK  = 32'h0000_0888;
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

    // CY and IR are always inhibitable; one extra bit per implemented HPM counter.
    function automatic logic [31:0] mci_mask(int n);
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int i = 0; i < n; i++) m[3+i] = 1'b1;
        return m;
    endfunction

    function automatic logic [11:0] hpm_addr(logic [11:0] base, int n);
        return base + 12'(n + 3);
    endfunction

    localparam logic [31:0] MCI_MASK = mci_mask(HPM_NUM);

    op_e         op;
    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q,   mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mcountinhibit_q, mcountinhibit_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,   mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q,   mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic [63:0] hpm_q [HPM_W];
    logic [63:0] hpm_d [HPM_W];
    logic [2:0]  irq_meta_q, irq_sync_q;  // {ext, timer, soft}

    logic [31:0] mstatus_rd, mip_rd, rdata, wval;
    logic        hit, ro, wr_en;

    assign op         = op_e'(exu_op_i);
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
    assign mip_rd     = {20'b0, irq_sync_q[2], 3'b0, irq_sync_q[1], 3'b0, irq_sync_q[0], 3'b0};

    // NOTE: every variable written in a combinational block gets a default at the
    // top, so no path through the case statements can infer a latch.
    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        ro    = 1'b0;
        case (exu_addr_i)
            A_MSTATUS:       rdata = mstatus_rd;
            A_MIE:           rdata = mie_q;
            A_MTVEC:         rdata = mtvec_q;
            A_MCOUNTINHIBIT: rdata = mcountinhibit_q;
            A_MSCRATCH:      rdata = mscratch_q;
            A_MEPC:          rdata = mepc_q;
            A_MCAUSE:        rdata = mcause_q;
            A_MIP:           begin rdata = mip_rd;              ro = 1'b1; end
            A_MCYCLE:        rdata = mcycle_q[31:0];
            A_MCYCLEH:       rdata = mcycle_q[63:32];
            A_MINSTRET:      rdata = minstret_q[31:0];
            A_MINSTRETH:     rdata = minstret_q[63:32];
            A_CYCLE:         begin rdata = mcycle_q[31:0];      ro = 1'b1; end
            A_CYCLEH:        begin rdata = mcycle_q[63:32];     ro = 1'b1; end
            A_INSTRET:       begin rdata = minstret_q[31:0];    ro = 1'b1; end
            A_INSTRETH:      begin rdata = minstret_q[63:32];   ro = 1'b1; end
            default:         hit = 1'b0;
        endcase
        for (int n = 0; n < HPM_NUM; n++) begin
            if (exu_addr_i == hpm_addr(A_MCYCLE, n)) begin
                rdata = hpm_q[n][31:0];
                hit   = 1'b1;
            end
            if (exu_addr_i == hpm_addr(A_MCYCLEH, n)) begin
                rdata = hpm_q[n][63:32];
                hit   = 1'b1;
            end
        end
    end

    assign exu_data_o    = rdata;
    assign exu_illegal_o = (op != OP_NONE) && (!hit || ro);
    assign wr_en         = (op != OP_NONE) && hit && !ro;

    always_comb begin
        case (op)
            OP_WRITE: wval = exu_data_i;
            OP_SET:   wval = rdata | exu_data_i;
            OP_CLEAR: wval = rdata & ~exu_data_i;
            default:  wval = rdata;
        endcase
    end

    // Lowest priority first; each later stage overrides the ones before it.
    always_comb begin
        mstatus_mie_d   = mstatus_mie_q;
        mstatus_mpie_d  = mstatus_mpie_q;
        mie_d           = mie_q;
        mtvec_d         = mtvec_q;
        mcountinhibit_d = mcountinhibit_q;
        mscratch_d      = mscratch_q;
        mepc_d          = mepc_q;
        mcause_d        = mcause_q;
        mcycle_d        = mcycle_q;
        minstret_d      = minstret_q;
        for (int n = 0; n < HPM_W; n++) hpm_d[n] = hpm_q[n];

        if (!mcountinhibit_q[0]) mcycle_d = mcycle_q + 64'd1;
        if (retire_i && !mcountinhibit_q[2]) minstret_d = minstret_q + 64'd1;
        for (int n = 0; n < HPM_NUM; n++) begin
            if (hpm_event_i[n] && !mcountinhibit_q[3+n]) hpm_d[n] = hpm_q[n] + 64'd1;
        end

        if (wr_en) begin
            case (exu_addr_i)
                A_MSTATUS: begin
                    mstatus_mie_d  = wval[3];
                    mstatus_mpie_d = wval[7];
                end
                A_MIE:           mie_d           = wval & MIE_MASK;
                A_MTVEC:         mtvec_d         = wval & ADDR_MASK;
                A_MCOUNTINHIBIT: mcountinhibit_d = wval & MCI_MASK;
                A_MSCRATCH:      mscratch_d      = wval;
                A_MEPC:          mepc_d          = wval & ADDR_MASK;
                A_MCAUSE:        mcause_d        = wval;
                A_MCYCLE:        mcycle_d        = {mcycle_q[63:32], wval};
                A_MCYCLEH:       mcycle_d        = {wval, mcycle_q[31:0]};
                A_MINSTRET:      minstret_d      = {minstret_q[63:32], wval};
                A_MINSTRETH:     minstret_d      = {wval, minstret_q[31:0]};
                default: ;
            endcase
            for (int n = 0; n < HPM_NUM; n++) begin
                if (exu_addr_i == hpm_addr(A_MCYCLE, n))  hpm_d[n] = {hpm_q[n][63:32], wval};
                if (exu_addr_i == hpm_addr(A_MCYCLEH, n)) hpm_d[n] = {wval, hpm_q[n][31:0]};
            end
        end

        if (trap_i) begin
            mepc_d         = trap_pc_i & ADDR_MASK;
            mcause_d       = trap_cause_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mstatus_mie_q   <= 1'b0;
            mstatus_mpie_q  <= 1'b0;
            mie_q           <= '0;
            mtvec_q         <= MTVEC_RST & ADDR_MASK;
            mcountinhibit_q <= '0;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mcycle_q        <= '0;
            minstret_q      <= '0;
            for (int n = 0; n < HPM_W; n++) hpm_q[n] <= '0;
            irq_meta_q      <= '0;
            irq_sync_q      <= '0;
        end else begin
            mstatus_mie_q   <= mstatus_mie_d;
            mstatus_mpie_q  <= mstatus_mpie_d;
            mie_q           <= mie_d;
            mtvec_q         <= mtvec_d;
            mcountinhibit_q <= mcountinhibit_d;
            mscratch_q      <= mscratch_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            mcycle_q        <= mcycle_d;
            minstret_q      <= minstret_d;
            for (int n = 0; n < HPM_W; n++) hpm_q[n] <= hpm_d[n];
            irq_meta_q      <= {irq_ext_i, irq_timer_i, irq_soft_i};
            irq_sync_q      <= irq_meta_q;
        end
    end

    assign csr_mtvec_o   = mtvec_q;
    assign csr_mepc_o    = mepc_q;
    assign csr_mstatus_o = mstatus_rd;
    assign irq_pending_o = mstatus_mie_q & (|(mie_q & mip_rd));

endmodule

// File: doc/csr_file.md
# csr_file

Parametrised machine-mode CSR file for the RV32 core, successor to the fixed six-register CSR block. Serves the execute unit through a single atomic read-modify-write port (write/set/clear). Takes trap entry and `mret` as dedicated hardware events rather than generic write ports. Adds 64-bit `mcycle`/`minstret`, a configurable bank of hardware performance counters, `mcountinhibit`, a live `mip`, field-level write masking and an illegal-access flag. It sits beside the EXU and the interrupt controller (clint) in the core.

## Interface
- HPM_NUM, 2, number of mhpmcounter3..(3+HPM_NUM-1); legal range 0..8
- MTVEC_RST, 32'h0000_0000, reset value of mtvec (bits [1:0] ignored)
- clk  in  1  core clock
- rstn  in  1  reset, asynchronous, active-low
- exu_op_i  in  2  00 none, 01 write, 10 set, 11 clear
- exu_addr_i  in  12  CSR address for read and write
- exu_data_i  in  32  write data / set-clear mask
- exu_data_o  out  32  current (pre-update) value of exu_addr_i
- exu_illegal_o  out  1  access to unimplemented or read-only CSR
- retire_i  in  1  one instruction retired this cycle
- hpm_event_i  in  HPM_NUM  per-counter increment strobes
- trap_i  in  1  trap entry pulse
- trap_pc_i  in  32  PC to store in mepc
- trap_cause_i  in  32  value for mcause
- mret_i  in  1  mret retire pulse
- irq_ext_i, irq_timer_i, irq_soft_i  in  1 each  asynchronous interrupt lines
- csr_mtvec_o, csr_mepc_o, csr_mstatus_o  out  32  live register values
- irq_pending_o  out  1  mstatus.MIE & |(mie & mip)

## Operation
- Implemented addresses:
  - mstatus 0x300, mie 0x304, mtvec 0x305, mcountinhibit 0x320
  - mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82
  - mhpmcounterN/Nh 0xB00+N / 0xB80+N for N=3..2+HPM_NUM
  - read-only mirrors cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82
- All other addresses read 0 and raise exu_illegal_o whenever exu_op_i != 0.
- Write value by op: new = data (write), old|data (set), old&~data (clear).
- Field masks:
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - mtvec[1:0] and mepc[1:0] read 0 (direct mode only).
  - mie: only bits 3, 7, 11 are writable.
  - mcountinhibit: bits 0 (CY), 2 (IR) and 3..2+HPM_NUM are writable.
- mip is read-only: bit 11 ext, bit 7 timer, bit 3 soft, each taken through a 2-flop synchroniser. Any write-class op to mip or to 0xCxx is illegal and has no effect.
- Counters are 64 bit and wrap from 2^64-1 to 0.
  - mcycle increments every cycle unless CY is inhibited.
  - minstret increments on retire_i unless IR is inhibited.
  - HPM N increments on hpm_event_i[N-3] unless its inhibit bit is set.
- Update priority per register, highest first:
  1. rstn
  2. trap_i
  3. mret_i
  4. EXU write
  5. counter increment
- trap_i: mepc<=trap_pc_i&~3, mcause<=trap_cause_i, MPIE<=MIE, MIE<=0. A same-cycle EXU write to mepc, mcause or mstatus is dropped; EXU writes to other CSRs still apply.
- mret_i: MIE<=MPIE, MPIE<=1. If trap_i and mret_i are both high, trap_i wins and mret_i is ignored.
- An EXU write to any counter half replaces that half. The other half is kept unchanged, and the increment is suppressed for that counter that cycle.

## Timing
- Reset values:
  - all CSRs 0 except mtvec=MTVEC_RST&~3 and mstatus=32'h0000_1800
  - synchroniser flops 0
  - exu_illegal_o=0, irq_pending_o=0
- exu_data_o and exu_illegal_o are combinational from exu_addr_i/exu_op_i and register state. They show the value before this cycle's update (no write bypass).
- All register updates take effect at the next rising clk edge; the csr_*_o outputs reflect the update one cycle after the write.
- irq_pending_o is combinational from registers. It rises no earlier than 2 cycles after an irq_*_i line rises (synchroniser latency).
- Asserting rstn low mid-operation clears all state asynchronously, regardless of any pending op.

## Test plan
- Reset, then read 0x300, 0x305, 0xB00 -> 0x1800, MTVEC_RST&~3, 0; a cycle later 0xB00 reads 1.
- Write 0x300 with 0xFFFF_FFFF, set 0x304 with 0x888, clear 0x304 with 0x080 -> mstatus reads 0x1888; mie reads 0x808; each exu_data_o shows the pre-write value.
- trap_i (pc 0x8000_0102, cause 0x8000_0007) with MIE=1, then mret_i -> mepc 0x8000_0100, mcause 0x8000_0007, mstatus 0x1880; after mret mstatus 0x1888.
- Write mcycle=0xFFFF_FFFF and mcycleh=0xFFFF_FFFF, then let it run -> 64-bit value wraps to 0 then 1. Set mcountinhibit bit 0 -> mcycle holds.
- Raise irq_timer_i with mie[7]=1 and MIE=1 -> irq_pending_o high on the 2nd edge; mip reads 0x80. Write 0x344 or 0xC00 -> exu_illegal_o=1 and state unchanged.
- HPM_NUM=2: pulse hpm_event_i=2'b11 for 5 cycles -> 0xB03 and 0xB04 read 5. Read 0xB05 with op=01 -> illegal, value 0.
